regfile_ctrl: RTL

//  Multi-cycle instruction sequencer that drives the 16x8 register file's ports:
//  two combinational read ports (ra1/rd1, ra2/rd2) and one clocked write port (we/wa3/wd3).

---
 rtl/regfile_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: multi-cycle instruction sequencer in front of a 16x8 register file.
//
// Takes one 16-bit instruction {op, rd, rs1, rs2} per valid/ready handshake. It reads
// the two operands through the register file's combinational read ports, runs one ALU
// op and writes the result back through the clocked write port. There is no overlap
// between instructions.
//
// Sequence:     IDLE -> READ -> EXEC -> WB -> IDLE (one instruction every 4 cycles)
// Retire point: done is high in the 3rd cycle after the accept edge.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   in_valid/in_ready  instruction handshake; in_ready is high only in IDLE
//   instr              {op[15:12], rd[11:8], rs1[7:4], rs2[3:0]}
//   ra1/rd1, ra2/rd2   register file read ports (the read data is combinational)
//   we/wa3/wd3         register file write port, committed at the end of WB
//   done, illegal      one-cycle retire pulse, plus the illegal-op qualifier
//   result, flags      result and Z/C of the last retired instruction (held)
module regfile_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  output logic              we,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  output logic              illegal
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e              state_q;
  logic [15:0]         instr_q;
  logic [DATA_W-1:0]   opa_q, opb_q;
  logic [ADDR_W-1:0]   ra1_q, ra2_q, wa3_q;
  logic [DATA_W-1:0]   wd3_q, result_q;
  logic                in_ready_q, we_q, done_q, illegal_q, flag_z_q, flag_c_q;

  // ALU decode of the latched instruction, consumed at the end of EXEC
  logic [DATA_W:0]     sum, diff;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_wr, alu_set_res, alu_set_flags, alu_ill;

  always_comb begin
    sum           = {1'b0, opa_q} + {1'b0, opb_q};
    diff          = {1'b0, opa_q} - {1'b0, opb_q};
    alu_res       = '0;
    alu_c         = 1'b0;
    alu_wr        = 1'b0;
    alu_set_res   = 1'b0;
    alu_set_flags = 1'b0;
    alu_ill       = 1'b0;
    case (instr_q[15:12])
      4'h0: begin
        // NOP: retires without touching result, flags or the register file
      end
      4'h1: begin
        alu_res     = DATA_W'(instr_q[7:0]);
        alu_wr      = 1'b1;
        alu_set_res = 1'b1;
      end
      4'h2: begin
        alu_res     = opa_q;
        alu_wr      = 1'b1;
        alu_set_res = 1'b1;
      end
      4'h3: begin
        alu_res       = sum[DATA_W-1:0];
        alu_c         = sum[DATA_W];
        alu_wr        = 1'b1;
        alu_set_res   = 1'b1;
        alu_set_flags = 1'b1;
      end
      4'h4, 4'h8: begin
        // CMP is SUB without the write; the top bit of the difference is the borrow
        alu_res       = diff[DATA_W-1:0];
        alu_c         = diff[DATA_W];
        alu_wr        = (instr_q[15:12] == 4'h4);
        alu_set_res   = 1'b1;
        alu_set_flags = 1'b1;
      end
      4'h5: begin
        alu_res       = opa_q & opb_q;
        alu_wr        = 1'b1;
        alu_set_res   = 1'b1;
        alu_set_flags = 1'b1;
      end
      4'h6: begin
        alu_res       = opa_q | opb_q;
        alu_wr        = 1'b1;
        alu_set_res   = 1'b1;
        alu_set_flags = 1'b1;
      end
      4'h7: begin
        alu_res       = opa_q ^ opb_q;
        alu_wr        = 1'b1;
        alu_set_res   = 1'b1;
        alu_set_flags = 1'b1;
      end
      default: begin
        alu_ill = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      ra1_q      <= '0;
      ra2_q      <= '0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      result_q   <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
    end else begin
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            instr_q    <= instr;
            ra1_q      <= ADDR_W'(instr[7:4]);
            ra2_q      <= ADDR_W'(instr[3:0]);
            in_ready_q <= 1'b0;
            state_q    <= StRead;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        StRead: begin
          opa_q   <= rd1;
          opb_q   <= rd2;
          state_q <= StExec;
        end
        StExec: begin
          wd3_q     <= alu_res;
          wa3_q     <= ADDR_W'(instr_q[11:8]);
          we_q      <= alu_wr;
          done_q    <= 1'b1;
          illegal_q <= alu_ill;
          if (alu_set_res) begin
            result_q <= alu_res;
          end
          if (alu_set_flags) begin
            flag_z_q <= (alu_res == '0);
            flag_c_q <= alu_c;
          end
          state_q <= StWb;
        end
        StWb: begin
          in_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // A reset arriving in WB must stop the register file commit in that very cycle
  assign we       = we_q && !reset;
  assign in_ready = in_ready_q;
  assign ra1      = ra1_q;
  assign ra2      = ra2_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign result   = result_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;

endmodule
